// File: rtl/stdout_uart_tx.sv
// stdout_uart_tx: buffered 8N1 UART transmitter for the core's console output.
// Bytes written by the core land in a small circular FIFO; a four-state FSM
// drains the FIFO one frame at a time onto the registered serial line.
module stdout_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       busy,
    output logic       overflow,
    output logic       tx
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    state_t            r_state;
    state_t            w_stateNext;
    logic [7:0]        r_shift;
    logic [7:0]        w_shiftNext;
    logic [2:0]        r_bitCnt;
    logic [2:0]        w_bitCntNext;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baudNext;
    logic              r_tx;
    logic              w_txNext;

    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_baudEnd;

    // Fullness is judged on the current count, so a pop in the same cycle
    // never makes room for a write that arrives while full.
    assign w_full    = (r_count == DEPTH_C);
    assign w_push    = wr_en & ~w_full;
    assign w_baudEnd = (r_baud == BAUD_LAST);

    assign full     = w_full;
    assign busy     = (r_state != S_IDLE) | (r_count != '0);
    assign overflow = r_overflow;
    assign tx       = r_tx;

    // Byte storage; contents need no reset because the count guards reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= wr_data;
        end
    end

    // FIFO pointers, occupancy count and the sticky dropped-byte flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Transmitter state register; the line itself is registered too.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_bitCnt <= '0;
            r_baud   <= '0;
            r_tx     <= 1'b1;
        end else begin
            r_state  <= w_stateNext;
            r_shift  <= w_shiftNext;
            r_bitCnt <= w_bitCntNext;
            r_baud   <= w_baudNext;
            r_tx     <= w_txNext;
        end
    end

    // Frame sequencing plus the next line level derived from the next state.
    always_comb begin
        w_stateNext  = r_state;
        w_shiftNext  = r_shift;
        w_bitCntNext = r_bitCnt;
        w_baudNext   = w_baudEnd ? '0 : r_baud + 1'b1;
        w_pop        = 1'b0;
        w_txNext     = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_baudNext = '0;
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_shiftNext  = r_mem[r_rdPtr];
                    w_bitCntNext = '0;
                    w_stateNext  = S_START;
                end
            end
            S_START: begin
                if (w_baudEnd) begin
                    w_stateNext = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baudEnd) begin
                    w_shiftNext = {1'b0, r_shift[7:1]};
                    if (r_bitCnt == 3'd7) begin
                        w_stateNext = S_STOP;
                    end else begin
                        w_bitCntNext = r_bitCnt + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_baudEnd) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase

        case (w_stateNext)
            S_START: w_txNext = 1'b0;
            S_DATA:  w_txNext = w_shiftNext[0];
            default: w_txNext = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_stdout_uart_tx.sv
// tb_stdout_uart_tx: directed bench for the console UART transmitter with
// four clocks per bit, a background serial receiver and immediate assertions.
module tb_stdout_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;

    logic       clk;
    logic       reset_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       busy;
    logic       overflow;
    logic       tx;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] rxQ[$];
    int         startQ[$];
    bit         okQ[$];

    logic [7:0] monData;
    logic       monStart;
    logic       monStop;
    logic       monAbort;
    int         monCyc;

    stdout_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .busy    (busy),
        .overflow(overflow),
        .tx      (tx)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle stamp used to measure start-bit spacing.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Serial receiver: samples each bit mid-period and drops frames cut by reset.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && tx === 1'b0) begin
                monCyc   = cyc;
                monAbort = 1'b0;
                monStart = 1'b1;
                monStop  = 1'b0;
                monData  = 8'h00;
                for (int off = 1; off <= 38; off++) begin
                    @(negedge clk);
                    if (reset_n !== 1'b1) monAbort = 1'b1;
                    if (off == 2) monStart = tx;
                    if (off >= 6 && off <= 34 && ((off - 6) % 4) == 0)
                        monData[3'((off - 6) / 4)] = tx;
                    if (off == 38) monStop = tx;
                end
                if (!monAbort) begin
                    rxQ.push_back(monData);
                    startQ.push_back(monCyc);
                    okQ.push_back(monStart == 1'b0 && monStop == 1'b1);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        checkOutput(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic clearRx;
        rxQ.delete();
        startQ.delete();
        okQ.delete();
    endtask

    task automatic doReset;
        reset_n = 1'b0;
        tick();
        checkOutput("rstTx", {31'd0, tx}, 32'd1);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstFull", {31'd0, full}, 32'd0);
        checkOutput("rstOvf", {31'd0, overflow}, 32'd0);
        reset_n = 1'b1;
    endtask

    // Directed sequence: idle line, single frame, back-to-back, overflow,
    // pointer wrap, reset mid-frame.
    initial begin
        logic [9:0] frame41;
        int         bad;
        int         badBusy;
        logic [7:0] exp8;

        frame41 = 10'b1_0100_0001_0;
        reset_n = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        tick();
        doReset();

        // Idle line for 1000 cycles.
        bad = 0;
        badBusy = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (tx !== 1'b1) bad++;
            if (busy !== 1'b0) badBusy++;
        end
        checkOutput("idleTx", bad, 0);
        checkOutput("idleBusy", badBusy, 0);

        // Single byte 0x41 with exact bit timing.
        clearRx();
        applyStimulus(8'h41);
        checkOutput("t1Busy", {31'd0, busy}, 32'd1);
        checkOutput("t1TxHigh", {31'd0, tx}, 32'd1);
        for (int off = 0; off < 40; off++) begin
            tick();
            checkOutput("t1Bit", {31'd0, tx}, {31'd0, frame41[off / 4]});
        end
        checkOutput("t1BusyLast", {31'd0, busy}, 32'd1);
        tick();
        checkOutput("t1BusyFall", {31'd0, busy}, 32'd0);
        checkOutput("t1Ovf", {31'd0, overflow}, 32'd0);
        checkOutput("t1RxCount", rxQ.size(), 1);
        checkOutput("t1RxData", (rxQ.size() > 0) ? {24'd0, rxQ[0]} : 32'hFFFF_FFFF, 32'h41);

        // Back-to-back 0x55, 0xAA, 0x0D.
        clearRx();
        wr_en = 1'b1;
        wr_data = 8'h55;
        tick();
        wr_data = 8'hAA;
        tick();
        wr_data = 8'h0D;
        tick();
        wr_en = 1'b0;
        waitIdle("t2Idle", 400);
        tick();
        checkOutput("t2RxCount", rxQ.size(), 3);
        if (rxQ.size() == 3) begin
            checkOutput("t2Rx0", {24'd0, rxQ[0]}, 32'h55);
            checkOutput("t2Rx1", {24'd0, rxQ[1]}, 32'hAA);
            checkOutput("t2Rx2", {24'd0, rxQ[2]}, 32'h0D);
            checkOutput("t2Gap01", startQ[1] - startQ[0], 41);
            checkOutput("t2Gap12", startQ[2] - startQ[1], 41);
            checkOutput("t2Framing", {31'd0, okQ[0] & okQ[1] & okQ[2]}, 32'd1);
        end

        // Overflow: 18 consecutive writes 0x00..0x11.
        clearRx();
        wr_en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            wr_data = 8'(i);
            tick();
            if (i == 15) checkOutput("t3FullEarly", {31'd0, full}, 32'd0);
            if (i == 16) begin
                checkOutput("t3Full17", {31'd0, full}, 32'd1);
                checkOutput("t3OvfEarly", {31'd0, overflow}, 32'd0);
            end
            if (i == 17) begin
                checkOutput("t3Ovf18", {31'd0, overflow}, 32'd1);
                checkOutput("t3Full18", {31'd0, full}, 32'd1);
            end
        end
        wr_en = 1'b0;
        waitIdle("t3Idle", 1500);
        repeat (50) tick();
        checkOutput("t3RxCount", rxQ.size(), 17);
        for (int i = 0; i < 17; i++) begin
            checkOutput("t3RxOrder", (i < rxQ.size()) ? {24'd0, rxQ[i]} : 32'hFFFF_FFFF, i);
        end
        checkOutput("t3OvfSticky", {31'd0, overflow}, 32'd1);

        // Pointer wrap: 40 writes gated on !full, with draining pauses.
        doReset();
        clearRx();
        for (int i = 0; i < 40; i++) begin
            bad = 0;
            while (full !== 1'b0 && bad < 200) begin
                tick();
                bad++;
            end
            checkOutput("t4FullWait", {31'd0, full}, 32'd0);
            exp8 = 8'((i * 37 + 5) & 255);
            applyStimulus(exp8);
            if (i % 8 == 7) repeat (150) tick();
        end
        waitIdle("t4Idle", 2500);
        tick();
        checkOutput("t4RxCount", rxQ.size(), 40);
        for (int i = 0; i < 40; i++) begin
            exp8 = 8'((i * 37 + 5) & 255);
            checkOutput("t4RxOrder", (i < rxQ.size()) ? {24'd0, rxQ[i]} : 32'hFFFF_FFFF, {24'd0, exp8});
        end
        checkOutput("t4Ovf", {31'd0, overflow}, 32'd0);
        checkOutput("t4Busy", {31'd0, busy}, 32'd0);

        // Reset during DATA of the first of five queued frames.
        clearRx();
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 8'(8'h31 + i);
            tick();
        end
        wr_en = 1'b0;
        repeat (10) tick();
        doReset();
        bad = 0;
        badBusy = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (tx !== 1'b1) bad++;
            if (busy !== 1'b0) badBusy++;
        end
        checkOutput("t5QuietTx", bad, 0);
        checkOutput("t5QuietBusy", badBusy, 0);
        checkOutput("t5NoFrames", rxQ.size(), 0);
        applyStimulus(8'h7E);
        waitIdle("t5Idle", 200);
        tick();
        checkOutput("t5RxCount", rxQ.size(), 1);
        checkOutput("t5RxData", (rxQ.size() > 0) ? {24'd0, rxQ[0]} : 32'hFFFF_FFFF, 32'h7E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
